cpu_alu_mc: RTL and testbench

- Multi-cycle, parametrised ALU for the execute stage.
- Extends the base integer op set (add, sub, logic, shifts, compares) with RV M-extension multiply/divide/remainder.
- Uses a valid/ready handshake on both input and output so execute can stall on long ops.
- Base ops complete in 1 cycle; multiply is iterative, divide is a restoring divider.

---
 rtl/cpu_alu_pkg.sv | 63 ++++++
 rtl/cpu_alu_div.sv | 67 ++++++
 rtl/cpu_alu_mc.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_alu_mc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU: operation codes,
// FSM states and small operation-class helpers.
package cpu_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_mul_op(input alu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_div_op(input alu_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(input alu_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Operand a/b is interpreted as two's complement for these ops.
  function automatic logic a_is_signed(input alu_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_is_signed(input alu_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  // Sign of the full product when multiplying operand magnitudes.
  function automatic logic mul_negate(input alu_op_t op, input logic a_sign, input logic b_sign);
    case (op)
      OP_MULH:   return a_sign ^ b_sign;
      OP_MULHSU: return a_sign;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_alu_div.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done is high in the cycle whose step completes; quotient/remainder then hold the final values.
module cpu_alu_div
  import cpu_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [XLEN-1:0] quo_nxt, rem_nxt;
  logic [XLEN:0]   partial, diff;

  // The quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  always_comb begin
    partial = {rem_q, quo_q[XLEN-1]};
    diff    = partial - {1'b0, dvs_q};
    if (diff[XLEN]) begin
      rem_nxt = partial[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign done      = busy_q && (cnt_q == CW'(XLEN - 1));
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle base ops, iterative shift-add
// multiply and restoring divide, with valid/ready on both sides.
module cpu_alu_mc
  import cpu_alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less_than,
  output logic            unsigned_less_than
);

  localparam int SHW       = $clog2(XLEN);
  localparam int MUL_STEPS = XLEN / MUL_BITS;
  localparam int CW        = $clog2(MUL_STEPS + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  alu_op_t         op_in, op_q;
  logic            accept, finalize, load_result;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [SHW-1:0]  shamt;
  logic            div_by_zero, div_ovf, fast_div, one_cycle;
  logic            lt_in, ltu_in, lt_cap, ltu_cap;
  logic [XLEN-1:0] base_result, fin_result, next_result;
  logic [XLEN-1:0] result_q;
  logic            zero_q, lt_q, ltu_q;
  logic [CW-1:0]   cnt_q;
  logic            mul_last;
  logic [2*XLEN-1:0] mul_acc_q, mul_mcand_q, mul_sum, mul_prod;
  logic [XLEN-1:0] mul_mplier_q;
  logic            mul_neg_q;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem, div_fixed;

  assign op_in  = alu_op_t'(control);
  assign shamt  = operand_b[SHW-1:0];
  assign lt_in  = $signed(operand_a) < $signed(operand_b);
  assign ltu_in = operand_a < operand_b;
  assign lt_cap  = $signed(a_q) < $signed(b_q);
  assign ltu_cap = a_q < b_q;

  // Both long datapaths work on magnitudes; signs are restored on the final cycle.
  assign a_mag = (a_is_signed(op_in) && operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign b_mag = (b_is_signed(op_in) && operand_b[XLEN-1]) ? -operand_b : operand_b;

  assign div_by_zero = (operand_b == '0);
  assign div_ovf     = (op_in == OP_DIV || op_in == OP_REM) &&
                       (operand_a == MOST_NEG) && (operand_b == '1);
  assign fast_div    = is_div_op(op_in) && (div_by_zero || div_ovf);
  assign one_cycle   = !is_mul_op(op_in) && (!is_div_op(op_in) || fast_div);

  always_comb begin
    base_result = '0;
    case (op_in)
      OP_ADD:  base_result = operand_a + operand_b;
      OP_SUB:  base_result = operand_a - operand_b;
      OP_AND:  base_result = operand_a & operand_b;
      OP_OR:   base_result = operand_a | operand_b;
      OP_XOR:  base_result = operand_a ^ operand_b;
      OP_SLL:  base_result = operand_a << shamt;
      OP_SRL:  base_result = operand_a >> shamt;
      OP_SRA:  base_result = $signed(operand_a) >>> shamt;
      OP_SLT:  base_result = {{(XLEN-1){1'b0}}, lt_in};
      OP_SLTU: base_result = {{(XLEN-1){1'b0}}, ltu_in};
      OP_DIV, OP_DIVU: base_result = div_by_zero ? '1 : operand_a;
      OP_REM, OP_REMU: base_result = div_by_zero ? operand_a : '0;
      default: base_result = '0;
    endcase
  end

  always_comb begin
    mul_sum = mul_acc_q;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mul_mplier_q[i]) mul_sum = mul_sum + (mul_mcand_q << i);
    end
  end

  assign mul_last = (cnt_q == CW'(MUL_STEPS - 1));
  assign mul_prod = mul_neg_q ? -mul_sum : mul_sum;

  always_comb begin
    if (is_rem_op(op_q))
      div_fixed = (op_q == OP_REM && a_q[XLEN-1]) ? -div_rem : div_rem;
    else
      div_fixed = (op_q == OP_DIV && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quo : div_quo;
  end

  always_comb begin
    fin_result = '0;
    case (state_q)
      MUL:     fin_result = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
      DIV:     fin_result = div_fixed;
      default: fin_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept = 1'b1;
          if (is_mul_op(op_in)) begin
            state_d = MUL;
          end else if (one_cycle) begin
            state_d = DONE;
          end else begin
            state_d   = DIV;
            div_start = 1'b1;
          end
        end
      end
      MUL: begin
        if (flush)         state_d = IDLE;
        else if (mul_last) state_d = DONE;
      end
      DIV: begin
        if (flush)         state_d = IDLE;
        else if (div_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign finalize    = !flush && ((state_q == MUL && mul_last) || (state_q == DIV && div_done));
  assign load_result = (accept && one_cycle) || finalize;
  assign next_result = accept ? base_result : fin_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      cnt_q        <= '0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_neg_q    <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b1;
      lt_q         <= 1'b0;
      ltu_q        <= 1'b0;
    end else begin
      if (accept) begin
        a_q          <= operand_a;
        b_q          <= operand_b;
        op_q         <= op_in;
        cnt_q        <= '0;
        mul_acc_q    <= '0;
        mul_mcand_q  <= {{XLEN{1'b0}}, a_mag};
        mul_mplier_q <= b_mag;
        mul_neg_q    <= mul_negate(op_in, operand_a[XLEN-1], operand_b[XLEN-1]);
      end else if (state_q == MUL && !flush) begin
        mul_acc_q    <= mul_sum;
        mul_mcand_q  <= mul_mcand_q << MUL_BITS;
        mul_mplier_q <= mul_mplier_q >> MUL_BITS;
        cnt_q        <= cnt_q + CW'(1);
      end
      // Flags are always registered together with the result they describe.
      if (load_result) begin
        result_q <= next_result;
        zero_q   <= (next_result == '0);
        lt_q     <= accept ? lt_in  : lt_cap;
        ltu_q    <= accept ? ltu_in : ltu_cap;
      end
    end
  end

  cpu_alu_div #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign result             = result_q;
  assign zero               = zero_q;
  assign less_than          = lt_q;
  assign unsigned_less_than = ltu_q;

endmodule

// File: tb/tb_cpu_alu_mc.sv
// Self-checking bench for cpu_alu_mc: directed cases, randomized ops against
// an arithmetic reference model, backpressure, flush, reset and a 64-bit instance.
module tb_cpu_alu_mc;
  import cpu_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] operand_a, operand_b, result;
  logic [4:0]  control;
  logic        zero, less_than, unsigned_less_than;

  logic        in_valid64, in_ready64, out_valid64, zero64, lt64, ltu64;
  logic [63:0] operand_a64, operand_b64, result64;
  logic [4:0]  control64;

  int n_cmp = 0;
  int n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  cpu_alu_mc #(.XLEN(32), .MUL_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .control(control), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .less_than(less_than), .unsigned_less_than(unsigned_less_than)
  );

  cpu_alu_mc #(.XLEN(64), .MUL_BITS(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
    .operand_a(operand_a64), .operand_b(operand_b64), .control(control64), .flush(1'b0),
    .out_valid(out_valid64), .out_ready(1'b1), .result(result64), .zero(zero64),
    .less_than(lt64), .unsigned_less_than(ltu64)
  );

  // Reference model straight from the RV integer/M-extension definitions.
  function automatic logic [31:0] refResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] ua, ub, p;
    int         sh;
    logic       ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sh  = int'(b[4:0]);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SLL:    return a << sh;
      OP_SRL:    return a >> sh;
      OP_SRA:    begin p = sa >>> sh; return p[31:0]; end
      OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd10 && op <= 5'd13) return 9;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 32'd0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request, then waits (bounded) for out_valid; lat counts edges from accept.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    in_valid  = 1'b1;
    control   = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    control   = 5'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expectOp(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    exp = refResult(op, a, b);
    applyStimulus(op, a, b);
    checkOutput({tag, ".result"}, 64'(result), 64'(exp));
    checkOutput({tag, ".zero"}, 64'(zero), 64'(exp == 32'd0));
    checkOutput({tag, ".lt"}, 64'(less_than), 64'($signed(a) < $signed(b)));
    checkOutput({tag, ".ltu"}, 64'(unsigned_less_than), 64'(a < b));
    checkOutput({tag, ".latency"}, 64'(lat), 64'(refLatency(op, a, b)));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        seen;
    int          sel;

    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    control = '0; operand_a = '0; operand_b = '0;
    in_valid64 = 1'b0; control64 = '0; operand_a64 = '0; operand_b64 = '0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset.result", 64'(result), 64'd0);
    checkOutput("reset.zero", 64'(zero), 64'd1);
    checkOutput("reset.lt", 64'(less_than), 64'd0);
    checkOutput("reset.ltu", 64'(unsigned_less_than), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed base and M ops");
    expectOp("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1);
    expectOp("sra", OP_SRA, 32'h8000_0000, 32'd4);
    expectOp("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1);
    expectOp("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000);
    expectOp("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
    expectOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    expectOp("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2);
    expectOp("divu_zero", OP_DIVU, 32'd5, 32'd0);
    expectOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expectOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    expectOp("reserved", 5'd25, 32'd7, 32'd9);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(OP_SUB, 32'hFFFF_FFFD, 32'd5);
    checkOutput("bp.latency", 64'(lat), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp.result", 64'(result), 64'h0000_0000_FFFF_FFF8);
      checkOutput("bp.zero", 64'(zero), 64'd0);
      checkOutput("bp.lt", 64'(less_than), 64'd1);
      checkOutput("bp.ltu", 64'(unsigned_less_than), 64'd0);
      checkOutput("bp.out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp.out_valid_after", 64'(out_valid), 64'd0);
    checkOutput("bp.in_ready_after", 64'(in_ready), 64'd1);

    $display("[TB] flush during divide");
    in_valid = 1'b1; control = OP_DIV; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("flush.no_valid", 64'(seen), 64'd0);
    checkOutput("flush.in_ready", 64'(in_ready), 64'd1);
    expectOp("after_flush_add", OP_ADD, 32'd2, 32'd3);

    $display("[TB] reset during multiply");
    in_valid = 1'b1; control = OP_MUL; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_mid.out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid.result", 64'(result), 64'd0);
    checkOutput("rst_mid.zero", 64'(zero), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    expectOp("after_reset_mul", OP_MUL, 32'hFFFF_FFFD, 32'd7);

    $display("[TB] randomized ops");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) op = 5'($urandom_range(18, 31));
      else                           op = 5'($urandom_range(0, 17));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 5); end
        3: b = 32'($signed(-32'($urandom_range(1, 9))));
        default: ;
      endcase
      expectOp("rand", op, a, b);
    end

    $display("[TB] 64-bit instance, one multiplier bit per cycle");
    in_valid64 = 1'b1; control64 = OP_MULHU;
    operand_a64 = 64'hFFFF_FFFF_FFFF_FFFF; operand_b64 = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    in_valid64 = 1'b0; operand_a64 = '0; operand_b64 = '0;
    lat = 1;
    while (!out_valid64 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("x64.mulhu.result", result64, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("x64.mulhu.latency", 64'(lat), 64'd65);
    checkOutput("x64.mulhu.zero", 64'(zero64), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
